// File: rtl/cgra_loader_pkg.sv
// Shared types and default geometry for the CGRA instruction loader.
// Defaults: 2 columns x 32-bit words in a 512-bit AXI beat gives 8 bundles per beat.
package cgra_loader_pkg;

    localparam int NUM_COL_DEF    = 2;
    localparam int DWIDTH_INT_DEF = 32;
    localparam int PHIT_SIZE_DEF  = 512;
    localparam int ADDR_WIDTH_DEF = 64;
    localparam int PC_WIDTH_DEF   = 12;
    localparam int MAX_BURST_DEF  = 64;

    localparam int BUNDLE_W   = NUM_COL_DEF * DWIDTH_INT_DEF;
    localparam int BPB        = PHIT_SIZE_DEF / BUNDLE_W;
    localparam int BEAT_BYTES = PHIT_SIZE_DEF / 8;

    typedef logic [BUNDLE_W-1:0] bundle_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_UNPACK = 3'd3,
        ST_DONE   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/cgra_instr_loader_unpacker.sv
// Beat buffer plus slot counter: holds one AXI beat and presents it one bundle per cycle.
module cgra_beat_unpacker #(
    parameter int PHIT_SIZE = 512,
    parameter int BUNDLE_W  = 64,
    parameter int SLOT_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [PHIT_SIZE-1:0] i_beat,
    input  logic                 i_next,
    input  logic [SLOT_W-1:0]    i_slot_limit,
    output logic [BUNDLE_W-1:0]  o_bundle,
    output logic                 o_last_slot
);

    logic [PHIT_SIZE-1:0] r_beat;
    logic [SLOT_W-1:0]    r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_slot <= '0;
        end else if (i_load) begin
            r_beat <= i_beat;
            r_slot <= '0;
        end else if (i_next) begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign o_bundle    = r_beat[32'(r_slot) * BUNDLE_W +: BUNDLE_W];
    assign o_last_slot = (r_slot == i_slot_limit);

endmodule

// File: rtl/cgra_instr_loader.sv
// AXI4 read master that fetches the CGRA instruction image and writes it,
// one bundle per cycle, into the column instruction memories.
module cgra_instr_loader
    import cgra_loader_pkg::*;
#(
    parameter int NUM_COL    = NUM_COL_DEF,
    parameter int DWIDTH_INT = DWIDTH_INT_DEF,
    parameter int PHIT_SIZE  = PHIT_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [PC_WIDTH:0]             num_bundles,
    input  logic                          m_axi_arready,
    output logic                          m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    input  logic [PHIT_SIZE-1:0]          m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axi_rready,
    output logic                          imem_we,
    output logic [PC_WIDTH-1:0]           imem_addr,
    output logic [NUM_COL*DWIDTH_INT-1:0] imem_wdata,
    output logic                          done_loader,
    output logic                          busy,
    output logic                          rlast_err
);

    localparam int BUNDLE_W_L = NUM_COL * DWIDTH_INT;
    localparam int BPB_L      = PHIT_SIZE / BUNDLE_W_L;
    localparam int SLOT_W     = (BPB_L > 1) ? $clog2(BPB_L) : 1;
    localparam int BPB_SHIFT  = $clog2(BPB_L);
    localparam int BEAT_SHIFT = $clog2(PHIT_SIZE / 8);
    localparam int CNT_W      = PC_WIDTH + 1;

    loader_state_e         r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_total_beats;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_received;
    logic [8:0]            r_burst_left;
    logic [SLOT_W-1:0]     r_last_limit;
    logic [PC_WIDTH-1:0]   r_bundle;
    logic                  r_rlast_err;

    logic [CNT_W-1:0]      w_num_clamped;
    logic [CNT_W-1:0]      w_total_beats;
    logic [CNT_W-1:0]      w_remaining;
    logic [CNT_W-1:0]      w_burst_beats;
    logic [SLOT_W-1:0]     w_slot_limit;
    logic                  w_beat_fire;
    logic                  w_exp_rlast;
    logic                  w_last_slot;
    logic [BUNDLE_W_L-1:0] w_bundle;

    assign w_num_clamped = (num_bundles > CNT_W'(1 << PC_WIDTH)) ? CNT_W'(1 << PC_WIDTH) : num_bundles;
    assign w_total_beats = (w_num_clamped + CNT_W'(BPB_L - 1)) >> BPB_SHIFT;
    assign w_remaining   = r_total_beats - r_issued;
    assign w_burst_beats = (w_remaining > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : w_remaining;
    assign w_beat_fire   = (r_state == ST_DATA) && m_axi_rvalid;
    assign w_exp_rlast   = (r_burst_left == 9'd1);
    // Only the final beat of the image may stop short of the last slot.
    assign w_slot_limit  = (r_received == r_total_beats) ? r_last_limit : SLOT_W'(BPB_L - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_base        <= '0;
            r_total_beats <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_burst_left  <= '0;
            r_last_limit  <= '0;
            r_bundle      <= '0;
            r_rlast_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_num_clamped == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_base        <= base_addr;
                            r_total_beats <= w_total_beats;
                            r_last_limit  <= SLOT_W'(w_num_clamped - CNT_W'(1));
                            r_issued      <= '0;
                            r_received    <= '0;
                            r_bundle      <= '0;
                            r_rlast_err   <= 1'b0;
                            r_state       <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        r_issued     <= r_issued + w_burst_beats;
                        r_burst_left <= 9'(w_burst_beats);
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_rvalid) begin
                        // Progress follows our own beat count; a wrong rlast is only flagged.
                        if (m_axi_rlast != w_exp_rlast) begin
                            r_rlast_err <= 1'b1;
                        end
                        r_received   <= r_received + CNT_W'(1);
                        r_burst_left <= r_burst_left - 9'd1;
                        r_state      <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_bundle <= r_bundle + PC_WIDTH'(1);
                    if (w_last_slot) begin
                        if (r_burst_left != '0) begin
                            r_state <= ST_DATA;
                        end else if (r_received != r_total_beats) begin
                            r_state <= ST_ADDR;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cgra_beat_unpacker #(
        .PHIT_SIZE (PHIT_SIZE),
        .BUNDLE_W  (BUNDLE_W_L),
        .SLOT_W    (SLOT_W)
    ) u_unpacker (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_beat_fire),
        .i_beat       (m_axi_rdata),
        .i_next       (r_state == ST_UNPACK),
        .i_slot_limit (w_slot_limit),
        .o_bundle     (w_bundle),
        .o_last_slot  (w_last_slot)
    );

    assign m_axi_arvalid = (r_state == ST_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? (r_base + (ADDR_WIDTH'(r_issued) << BEAT_SHIFT)) : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(w_burst_beats - CNT_W'(1)) : 8'd0;
    assign m_axi_rready  = (r_state == ST_DATA);
    assign imem_we       = (r_state == ST_UNPACK);
    assign imem_addr     = r_bundle;
    assign imem_wdata    = w_bundle;
    assign done_loader   = (r_state == ST_DONE);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign rlast_err     = r_rlast_err;

endmodule
